// File: rtl/mips_bus_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_bus_mem : Avalon-MM boot/data memory with programmable wait states  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module mips_bus_mem #(
  parameter int unsigned WAIT_CYCLES    = 2,
  parameter logic [31:0] BOOT_BASE      = 32'hBFC00000,
  parameter int unsigned BOOT_WORDS     = 1024,
  parameter logic [31:0] DATA_BASE      = 32'h00000000,
  parameter int unsigned DATA_WORDS     = 4096,
  parameter              BOOT_INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        bus_error
);

  localparam logic [1:0]  c_IDLE      = 2'd0;
  localparam logic [1:0]  c_WAIT      = 2'd1;
  localparam logic [1:0]  c_DONE      = 2'd2;
  localparam bit          c_ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam bit          c_ONE_WAIT  = (WAIT_CYCLES == 1);
  localparam logic [3:0]  c_WAIT_LOAD = 4'(WAIT_CYCLES - 1);
  localparam int unsigned c_BIDX_W    = (BOOT_WORDS > 1) ? $clog2(BOOT_WORDS) : 1;
  localparam int unsigned c_DIDX_W    = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
  localparam logic [32:0] c_BOOT_SPAN = 33'(BOOT_WORDS) * 33'd4;
  localparam logic [32:0] c_DATA_SPAN = 33'(DATA_WORDS) * 33'd4;
  localparam logic [31:0] c_ERR_WORD  = 32'hDEADBEEF;

  logic [31:0] boot_mem [BOOT_WORDS];
  logic [31:0] data_mem [DATA_WORDS];

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] hold_q;
  logic        err_q;

  logic        w_req, w_idle, w_complete, w_err, w_rd, w_wr, w_do_write;
  logic [31:0] w_addr, w_wdata, w_word, w_rdata_now, w_boot_off, w_data_off;
  logic [3:0]  w_be;
  logic        w_boot_hit, w_data_hit;
  logic [c_BIDX_W-1:0] w_boot_idx;
  logic [c_DIDX_W-1:0] w_data_idx;

  // In IDLE the live request is the transfer; afterwards only the latched copy counts.
  assign w_req   = read | write;
  assign w_idle  = (state_q == c_IDLE);
  assign w_addr  = w_idle ? address    : addr_q;
  assign w_rd    = w_idle ? read       : rd_q;
  assign w_wr    = w_idle ? write      : wr_q;
  assign w_wdata = w_idle ? writedata  : wdata_q;
  assign w_be    = w_idle ? byteenable : be_q;

  assign w_boot_off = w_addr - BOOT_BASE;
  assign w_data_off = w_addr - DATA_BASE;
  assign w_boot_hit = (w_addr >= BOOT_BASE) && ({1'b0, w_boot_off} < c_BOOT_SPAN);
  assign w_data_hit = (w_addr >= DATA_BASE) && ({1'b0, w_data_off} < c_DATA_SPAN);
  assign w_boot_idx = w_boot_off[c_BIDX_W+1:2];
  assign w_data_idx = w_data_off[c_DIDX_W+1:2];

  assign w_err       = (w_addr[1:0] != 2'b00) || !(w_boot_hit || w_data_hit) || (w_rd && w_wr);
  assign w_word      = w_boot_hit ? boot_mem[w_boot_idx] : data_mem[w_data_idx];
  assign w_rdata_now = w_err ? c_ERR_WORD : w_word;
  assign w_complete  = w_req && !rst && ((state_q == c_DONE) || (w_idle && c_ZERO_WAIT));
  assign w_do_write  = w_complete && w_wr && !w_err;

  assign waitrequest = w_req && (rst || !((state_q == c_DONE) || (w_idle && c_ZERO_WAIT)));
  assign readdata    = (w_complete && w_rd) ? w_rdata_now : hold_q;
  assign bus_error   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      c_IDLE: begin
        if (w_req && !c_ZERO_WAIT) begin
          addr_d  = address;
          rd_d    = read;
          wr_d    = write;
          wdata_d = writedata;
          be_d    = byteenable;
          cnt_d   = c_WAIT_LOAD;
          state_d = c_ONE_WAIT ? c_DONE : c_WAIT;
        end
      end
      c_WAIT: begin
        if (!w_req) begin
          state_d = c_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = c_DONE;
        end
      end
      c_DONE:  state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      hold_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      if (w_complete && w_rd) hold_q <= w_rdata_now;
      if (w_complete && w_err) err_q <= 1'b1;
    end
  end

  // Array contents survive reset; w_do_write is already gated by rst.
  always_ff @(posedge clk) begin
    if (w_do_write && w_boot_hit) begin
      for (int i = 0; i < 4; i++)
        if (w_be[i]) boot_mem[w_boot_idx][8*i +: 8] <= w_wdata[8*i +: 8];
    end else if (w_do_write) begin
      for (int i = 0; i < 4; i++)
        if (w_be[i]) data_mem[w_data_idx][8*i +: 8] <= w_wdata[8*i +: 8];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_mem.sv
`default_nettype none
// Self-checking bench for mips_bus_mem: a 2-wait instance driven from a vector
// table plus corner sequences, and a zero-wait instance for streaming reads.
module tb_mips_bus_mem;
  localparam int WAITS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] address = '0, writedata = '0;
  logic        read = 1'b0, write = 1'b0;
  logic [3:0]  byteenable = '0;
  logic        waitrequest, bus_error;
  logic [31:0] readdata;

  logic [31:0] z_address = '0, z_writedata = '0;
  logic        z_read = 1'b0, z_write = 1'b0;
  logic [3:0]  z_byteenable = '0;
  logic        z_waitrequest, z_bus_error;
  logic [31:0] z_readdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  mips_bus_mem #(.WAIT_CYCLES(WAITS)) dut (
    .clk(clk), .rst(rst), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
    .readdata(readdata), .bus_error(bus_error));

  mips_bus_mem #(.WAIT_CYCLES(0)) u_zero (
    .clk(clk), .rst(rst), .address(z_address), .read(z_read), .write(z_write),
    .writedata(z_writedata), .byteenable(z_byteenable), .waitrequest(z_waitrequest),
    .readdata(z_readdata), .bus_error(z_bus_error));

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One transfer on the 2-wait instance; returns with request dropped, state IDLE.
  task automatic xfer(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input logic [31:0] exp, input string name);
    int waits;
    bit done;
    logic [31:0] e;
    @(posedge clk); #1;
    read = r; write = w; address = a; writedata = wd; byteenable = be;
    if (r) sb.push_back(exp);
    waits = 0;
    done  = 1'b0;
    while (!done && waits <= 40) begin
      @(negedge clk);
      if (waitrequest) waits++;
      else done = 1'b1;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: waitrequest stuck high, got %0d cycles expected %0d", name, waits, WAITS);
      sb.delete();
    end else begin
      check({name, " waits"}, 32'(waits), 32'(WAITS));
      if (r) begin
        e = sb.pop_front();
        check({name, " rdata"}, readdata, e);
      end
    end
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
  endtask

  initial begin
    vec_t vecs[$];
    logic [5:0] pat;
    int waits;
    logic [31:0] e;

    vecs.push_back('{1'b0, 1'b1, 32'hBFC00000, 32'h24020005, 4'hF, 32'h0,        1'b0, "boot_wr0"});
    vecs.push_back('{1'b1, 1'b0, 32'hBFC00000, 32'h0,        4'hF, 32'h24020005, 1'b0, "boot_rd0"});
    vecs.push_back('{1'b0, 1'b1, 32'h00000010, 32'h11223344, 4'hF, 32'h0,        1'b0, "wr10_full"});
    vecs.push_back('{1'b0, 1'b1, 32'h00000010, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0, "wr10_lanes"});
    vecs.push_back('{1'b1, 1'b0, 32'h00000010, 32'h0,        4'h0, 32'h11BB33DD, 1'b0, "rd10_lanes"});
    vecs.push_back('{1'b0, 1'b1, 32'h00000014, 32'h12345678, 4'hF, 32'h0,        1'b0, "wr14"});
    vecs.push_back('{1'b0, 1'b1, 32'h00000014, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0, "wr14_be0"});
    vecs.push_back('{1'b1, 1'b0, 32'h00000014, 32'h0,        4'h0, 32'h12345678, 1'b0, "rd14"});
    vecs.push_back('{1'b0, 1'b1, 32'h00000020, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0, "wr20"});
    vecs.push_back('{1'b0, 1'b1, 32'h00003FFC, 32'h5A5A5A5A, 4'hF, 32'h0,        1'b0, "wr_data_last"});
    vecs.push_back('{1'b1, 1'b0, 32'h00003FFC, 32'h0,        4'h0, 32'h5A5A5A5A, 1'b0, "rd_data_last"});
    vecs.push_back('{1'b0, 1'b1, 32'hBFC00FFC, 32'h0BADF00D, 4'hF, 32'h0,        1'b0, "wr_boot_last"});
    vecs.push_back('{1'b1, 1'b0, 32'hBFC00FFC, 32'h0,        4'h0, 32'h0BADF00D, 1'b0, "rd_boot_last"});
    vecs.push_back('{1'b0, 1'b1, 32'h00000000, 32'h13579BDF, 4'hF, 32'h0,        1'b0, "wr00"});
    vecs.push_back('{1'b1, 1'b0, 32'h00000002, 32'h0,        4'h0, 32'hDEADBEEF, 1'b1, "rd_misaligned"});
    vecs.push_back('{1'b0, 1'b1, 32'h00004000, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, "wr_data_end"});
    vecs.push_back('{1'b1, 1'b0, 32'h00000000, 32'h0,        4'h0, 32'h13579BDF, 1'b1, "rd00_after_err"});
    vecs.push_back('{1'b1, 1'b0, 32'hBFBFFFFC, 32'h0,        4'h0, 32'hDEADBEEF, 1'b1, "rd_below_boot"});
    vecs.push_back('{1'b1, 1'b0, 32'hBFC01000, 32'h0,        4'h0, 32'hDEADBEEF, 1'b1, "rd_boot_end"});
    vecs.push_back('{1'b1, 1'b1, 32'h00000010, 32'h00000000, 4'hF, 32'hDEADBEEF, 1'b1, "rd_and_wr"});
    vecs.push_back('{1'b1, 1'b0, 32'h00000010, 32'h0,        4'h0, 32'h11BB33DD, 1'b1, "rd10_kept"});
    vecs.push_back('{1'b1, 1'b0, 32'h00000020, 32'h0,        4'h0, 32'hCAFEF00D, 1'b1, "rd20"});

    // Reset: a request during rst stalls, then everything comes up clear.
    repeat (2) @(posedge clk);
    #1 read = 1'b1;
    @(negedge clk);
    check("rst_wreq_with_req", {31'd0, waitrequest}, 32'd1);
    @(posedge clk); #1;
    read = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("reset_wreq", {31'd0, waitrequest}, 32'd0);
    check("reset_rdata", readdata, 32'd0);
    check("reset_err", {31'd0, bus_error}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      xfer(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].exp_rd, vecs[i].name);
      @(negedge clk);
      if (vecs[i].rd) check({vecs[i].name, " hold"}, readdata, vecs[i].exp_rd);
      check({vecs[i].name, " bus_error"}, {31'd0, bus_error}, {31'd0, vecs[i].exp_err});
    end

    // Inputs changed mid-transfer must not affect the latched request.
    @(posedge clk); #1;
    read = 1'b1; address = 32'h10; sb.push_back(32'h11BB33DD);
    @(negedge clk);
    waits = waitrequest ? 1 : 0;
    @(posedge clk); #1;
    address = 32'h14; write = 1'b0; byteenable = 4'hF;
    while (waitrequest && waits <= 40) begin
      @(negedge clk);
      if (waitrequest) waits++;
    end
    check("latched_waits", 32'(waits), 32'(WAITS));
    e = sb.pop_front();
    check("latched_rdata", readdata, e);
    @(posedge clk); #1 read = 1'b0;

    // Held request: each transfer pays the full wait again.
    @(posedge clk); #1;
    read = 1'b1; address = 32'h10;
    for (int i = 5; i >= 0; i--) begin
      @(negedge clk);
      pat[i] = waitrequest;
    end
    check("b2b_wreq_pattern", {26'd0, pat}, {26'd0, 6'b110110});
    check("b2b_rdata", readdata, 32'h11BB33DD);
    @(posedge clk); #1 read = 1'b0;

    // Abandon during WAIT, then a fresh read.
    @(posedge clk); #1;
    read = 1'b1; address = 32'h14;
    @(posedge clk); #1 read = 1'b0;
    @(negedge clk);
    check("abandon_wreq", {31'd0, waitrequest}, 32'd0);
    check("abandon_rdata", readdata, 32'h11BB33DD);
    xfer(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 32'h12345678, "after_abandon");

    // Reset during WAIT of a write.
    @(posedge clk); #1;
    write = 1'b1; address = 32'h20; writedata = 32'h00000000; byteenable = 4'hF;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_wreq", {31'd0, waitrequest}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; write = 1'b0;
    @(negedge clk);
    check("midrst_rdata", readdata, 32'd0);
    check("midrst_err", {31'd0, bus_error}, 32'd0);
    check("midrst_wreq_idle", {31'd0, waitrequest}, 32'd0);
    xfer(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFEF00D, "midrst_rd20");
    xfer(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h11BB33DD, "midrst_rd10");

    // Zero-wait instance: streaming writes then streaming reads.
    @(posedge clk); #1;
    z_write = 1'b1; z_byteenable = 4'hF;
    for (int i = 0; i < 3; i++) begin
      z_address = 32'(4 * i);
      z_writedata = 32'hA0000000 + 32'(i);
      @(negedge clk);
      check("zw_write_wreq", {31'd0, z_waitrequest}, 32'd0);
      @(posedge clk); #1;
    end
    z_write = 1'b0; z_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      z_address = 32'(4 * i);
      sb.push_back(32'hA0000000 + 32'(i));
      @(negedge clk);
      check("zw_read_wreq", {31'd0, z_waitrequest}, 32'd0);
      e = sb.pop_front();
      check("zw_read_rdata", z_readdata, e);
      @(posedge clk); #1;
    end
    z_address = 32'h2;
    @(negedge clk);
    check("zw_err_rdata", z_readdata, 32'hDEADBEEF);
    @(posedge clk); #1 z_read = 1'b0;
    @(negedge clk);
    check("zw_err_flag", {31'd0, z_bus_error}, 32'd1);
    check("zw_err_hold", z_readdata, 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
